// File: rtl/p19_nanov_alu_seq_pkg.sv
// p19_nanov_alu_seq_pkg
// Shared definitions for the nanoV serial ALU sequencer:
//   - 4-bit ALU op-code constants
//   - sequencer state type
//   - op_needs_carry_in(): ops that run as a + ~b + 1 start with carry set
package p19_nanov_alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    function automatic logic op_needs_carry_in(input logic [3:0] op);
        return op[1] | op[3];
    endfunction

endpackage

// File: rtl/p19_nanoV_alu.sv
// p19_nanoV_alu
// 1-bit serial ALU slice. Purely combinational; the caller owns the carry flop.
// Ports:
//   op     in  4  ALU op code
//   a, b   in  1  current operand bits
//   cy_in  in  1  carry into this bit
//   d      out 1  result bit (0 for unlisted op codes)
//   cy_out out 1  carry out of this bit (adder-type ops only)
//   lts    out 1  signed less-than, meaningful on the MSB of a subtract
module p19_nanoV_alu
    import p19_nanov_alu_seq_pkg::*;
(
    input  logic [3:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cy_in,
    output logic       d,
    output logic       cy_out,
    output logic       lts
);

    logic is_sub;
    logic b_eff;
    logic sum;
    logic carry;

    assign is_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    assign b_eff  = b ^ is_sub;
    assign sum    = a ^ b_eff ^ cy_in;
    assign carry  = (a & b_eff) | (cy_in & (a ^ b_eff));

    // Differing sign bits decide directly; equal signs fall back to the
    // sign of the difference.
    assign lts = (a != b) ? a : sum;

    always_comb begin
        d      = 1'b0;
        cy_out = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU: begin
                d      = sum;
                cy_out = carry;
            end
            OP_AND:  d = a & b;
            OP_OR:   d = a | b;
            OP_XOR:  d = a ^ b;
            default: d = 1'b0;
        endcase
    end

endmodule

// File: rtl/p19_nanov_alu_sequencer.sv
// p19_nanov_alu_sequencer
// Runs the 1-bit slice p19_nanoV_alu across an XLEN-bit operation, LSB first,
// one bit per clock, and assembles the parallel result (with SLT/SLTU fixup).
// Ports:
//   clk, rstn      clock; synchronous active-low reset
//   start, op      request + op code, accepted when ready
//   a, b           operands, sampled on the accept edge
//   ready          idle, can accept
//   busy           bits being processed
//   done           one-cycle result-valid pulse
//   result         parallel result, valid in the done cycle, held until next accept
//   zero           result==0 flag
// Build option: define P19_ALU_SEQ_ZERO_FLAG_EN to enable the zero flag;
// otherwise zero is tied low.
module p19_nanov_alu_sequencer
    import p19_nanov_alu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] a_sr_q, a_sr_d;
    logic [XLEN-1:0] b_sr_q, b_sr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;

    logic slice_d;
    logic slice_cy;
    logic slice_lts;
    logic last_bit;
    logic accept;

    p19_nanoV_alu u_slice (
        .op     (op_q),
        .a      (a_sr_q[0]),
        .b      (b_sr_q[0]),
        .cy_in  (carry_q),
        .d      (slice_d),
        .cy_out (slice_cy),
        .lts    (slice_lts)
    );

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign accept   = ready & start;
    assign last_bit = (cnt_q == CntW'(XLEN - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        result_d = result_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    op_d    = op;
                    cnt_d   = '0;
                    carry_d = op_needs_carry_in(op);
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                result_d = {slice_d, result_q[XLEN-1:1]};
                carry_d  = slice_cy;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                    // Compare ops discard the difference and keep only the verdict.
                    if (op_q == OP_SLT) begin
                        result_d = {{(XLEN-1){1'b0}}, slice_lts};
                    end else if (op_q == OP_SLTU) begin
                        result_d = {{(XLEN-1){1'b0}}, ~slice_cy};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            result_q <= result_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
        end
    end

`ifdef P19_ALU_SEQ_ZERO_FLAG_EN
    logic nz_q, nz_d;
    logic zero_q, zero_d;

    always_comb begin
        nz_d   = nz_q;
        zero_d = zero_q;
        if (accept) begin
            nz_d = 1'b0;
        end else if (busy) begin
            nz_d = nz_q | slice_d;
            if (last_bit) begin
                // Compare results are a single bit; judge only the fixed-up bit.
                if (op_q == OP_SLT || op_q == OP_SLTU) begin
                    nz_d = result_d[0];
                end
                zero_d = ~nz_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            nz_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            nz_q   <= nz_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_p19_nanov_alu_sequencer.sv
// tb_p19_nanov_alu_sequencer
// Self-checking bench: directed and random ops against a behavioural model,
// plus start-during-run, mid-op reset and back-to-back throughput scenarios.
// Define P19_ALU_SEQ_ZERO_FLAG_EN consistently with the RTL build.
module tb_p19_nanov_alu_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;

    int n_vec = 0;
    int n_err = 0;

    p19_nanov_alu_sequencer #(
        .XLEN (XLEN)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] model(input logic [3:0] o, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        case (o)
            4'b0000: return x + y;
            4'b1000: return x - y;
            4'b0010: return ($signed(x) < $signed(y)) ? XLEN'(1) : XLEN'(0);
            4'b0011: return (x < y) ? XLEN'(1) : XLEN'(0);
            4'b0111: return x & y;
            4'b0110: return x | y;
            4'b0100: return x ^ y;
            default: return '0;
        endcase
    endfunction

    function automatic logic zero_model(input logic [XLEN-1:0] r);
`ifdef P19_ALU_SEQ_ZERO_FLAG_EN
        return (r == '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [7];
        ops = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111, 4'b0110, 4'b0100};
        if ($urandom_range(3) == 0) return 4'($urandom);
        return ops[$urandom_range(6)];
    endfunction

    function automatic logic [XLEN-1:0] rand_word();
        case ($urandom_range(5))
            0:       return '0;
            1:       return '1;
            2:       return XLEN'($urandom_range(3));
            default: return XLEN'($urandom);
        endcase
    endfunction

    // Runs one op from IDLE (called #1 after an edge) and checks latency, result and zero.
    task automatic do_op(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input string name);
        logic [XLEN-1:0] exp_r;
        logic            exp_z;
        int              lat;
        exp_r = model(o, x, y);
        exp_z = zero_model(exp_r);
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready-before-start got %b want 1", name, ready);
        end
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); a = XLEN'($urandom); b = XLEN'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < XLEN + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat != XLEN) begin
            n_err++;
            $display("FAIL %s latency got %0d want %0d", name, lat, XLEN);
        end
        n_vec++;
        if (result !== exp_r) begin
            n_err++;
            $display("FAIL %s result got %h want %h (op %b a %h b %h)", name, result, exp_r, o, x, y);
        end
        n_vec++;
        if (zero !== exp_z) begin
            n_err++;
            $display("FAIL %s zero got %b want %b", name, zero, exp_z);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || ready !== 1'b1 || result !== exp_r) begin
            n_err++;
            $display("FAIL %s post-done got done=%b ready=%b result=%h want 0/1/%h",
                     name, done, ready, result, exp_r);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset got ready=%b busy=%b done=%b result=%h zero=%b want 1/0/0/0/0",
                     ready, busy, done, result, zero);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(4'b0000, 32'h0000_0005, 32'h0000_0003, "add_5_3");
        do_op(4'b1000, 32'h0000_0005, 32'h0000_0005, "sub_5_5");
        do_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, "slt_m1_1");
        do_op(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_m1_1");
        do_op(4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, "sltu_1_m1");
        do_op(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
        do_op(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, "and");
        do_op(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, "or");
        do_op(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, "xor");
        do_op(4'b0010, 32'h8000_0000, 32'h7FFF_FFFF, "slt_min_max");
        do_op(4'b0010, 32'h0000_0003, 32'h0000_0003, "slt_equal");
        do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, "unlisted_op");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(rand_op(), rand_word(), rand_word(), "random");
        end
    endtask

    task automatic test_result_stable();
        logic [XLEN-1:0] held;
        do_op(4'b0000, 32'h1111_2222, 32'h3333_4444, "stable_setup");
        held = 32'h4444_6666;
        for (int i = 0; i < 5; i++) begin
            a = XLEN'($urandom); b = XLEN'($urandom); op = 4'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if (result !== held) begin
                n_err++;
                $display("FAIL stable_idle got %h want %h", result, held);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [XLEN-1:0] exp_r;
        int              ndone;
        exp_r = model(4'b0000, 32'h0000_0100, 32'h0000_0023);
        start = 1'b1; op = 4'b0000; a = 32'h0000_0100; b = 32'h0000_0023;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i < 3 * XLEN; i++) begin
            start = (i >= 3 && i <= 6);
            op = 4'b0111; a = XLEN'($urandom); b = XLEN'($urandom);
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                n_vec++;
                if (result !== exp_r) begin
                    n_err++;
                    $display("FAIL ignore_start result got %h want %h", result, exp_r);
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL ignore_start done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        start = 1'b1; op = 4'b0100; a = XLEN'($urandom); b = XLEN'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got ready=%b busy=%b done=%b result=%h zero=%b want 1/0/0/0/0",
                     ready, busy, done, result, zero);
        end
        rstn = 1'b1;
        ndone = 0;
        for (int i = 0; i < XLEN + 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone != 0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid after got done_count=%0d ready=%b want 0/1", ndone, ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] q [$];
        logic [XLEN-1:0] exp_r;
        int              cyc;
        int              last_done;
        int              ndone;
        cyc = 0; last_done = -1; ndone = 0;
        start = 1'b1; op = rand_op(); a = rand_word(); b = rand_word();
        while (ndone < 5 && cyc < 10 * (XLEN + 2)) begin
            if (ready === 1'b1) q.push_back(model(op, a, b));
            @(posedge clk); #1;
            cyc++;
            op = rand_op(); a = rand_word(); b = rand_word();
            if (done === 1'b1) begin
                ndone++;
                exp_r = (q.size() > 0) ? q.pop_front() : ~result;
                n_vec++;
                if (result !== exp_r) begin
                    n_err++;
                    $display("FAIL b2b result got %h want %h", result, exp_r);
                end
                if (last_done >= 0) begin
                    n_vec++;
                    if (cyc - last_done != XLEN + 2) begin
                        n_err++;
                        $display("FAIL b2b spacing got %0d want %0d", cyc - last_done, XLEN + 2);
                    end
                end
                last_done = cyc;
            end
        end
        start = 1'b0;
        n_vec++;
        if (ndone != 5) begin
            n_err++;
            $display("FAIL b2b done_count got %0d want 5", ndone);
        end
        for (int i = 0; i < XLEN + 4 && ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_result_stable();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
